// File: rtl/count_mon_pkg.sv
// Shared definitions for the ripple-counter monitor: FSM state encoding and
// count-range helper.
package count_mon_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_ERROR = 2'd3;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with clear; at all-ones it either holds (SAT=1) or rolls to 0.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b1
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc) begin
      if (&q_q) q_d = SAT ? q_q : '0;
      else      q_d = q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/ripple_count_monitor.sv
// Watches a ripple counter's output: checks each step, tracks wraps, and
// drives a match pulse and a wrap-synchronous PWM. All outputs are registered.
module ripple_count_monitor
  import count_mon_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int WRAP_W = 8,
  parameter bit SAT    = 1'b1
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr_err,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic [CNT_W-1:0]  duty,
  input  logic [CNT_W-1:0]  match,
  output logic              pwm,
  output logic              match_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err,
  output logic [1:0]        state
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt_q, prev_q, duty_q, duty_d;
  state_t           state_q, state_d;
  logic             pwm_q, pwm_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;
  logic             wc_inc, wc_clr;

  logic [CNT_W-1:0] prev_inc;
  logic             step_ok, wrap_ev, arrive_ev, run_d;

  assign prev_inc  = prev_q + CNT_W'(1);
  assign step_ok   = (cnt_q == prev_q) || (cnt_q == prev_inc);
  assign wrap_ev   = (prev_q == CNT_MAX) && (cnt_q == '0);
  assign arrive_ev = (cnt_q != prev_q) && (cnt_q == match);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    wc_inc  = 1'b0;
    wc_clr  = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (wrap_ev) begin
          state_d = ST_RUN;
          duty_d  = duty;
          wc_clr  = 1'b1;
        end
      end
      ST_RUN: begin
        // A bad step outranks both disable and a coincident wrap.
        if (!step_ok) begin
          state_d = ST_ERROR;
        end else if (!en) begin
          state_d = ST_IDLE;
        end else if (wrap_ev) begin
          wrap_d = 1'b1;
          wc_inc = 1'b1;
          duty_d = duty;
        end
      end
      default: begin
        if (clr_err) state_d = ST_IDLE;
      end
    endcase
  end

  // PWM compares against the duty that will be live after this edge, so a
  // new duty applies from count 0 of the period that starts at the wrap.
  assign run_d   = (state_d == ST_RUN);
  assign pwm_d   = run_d && (cnt_q < duty_d);
  assign match_d = run_d && arrive_ev;

  always_ff @(posedge Clk) begin
    if (rst) begin
      cnt_q   <= '0;
      prev_q  <= '0;
      duty_q  <= '0;
      state_q <= ST_IDLE;
      pwm_q   <= 1'b0;
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_in;
      prev_q  <= cnt_q;
      duty_q  <= duty_d;
      state_q <= state_d;
      pwm_q   <= pwm_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
    end
  end

  sat_counter #(
    .WIDTH (WRAP_W),
    .SAT   (SAT)
  ) u_wrap_cnt (
    .Clk (Clk),
    .rst (rst),
    .inc (wc_inc),
    .clr (wc_clr),
    .q   (wrap_count)
  );

  assign pwm         = pwm_q;
  assign match_pulse = match_q;
  assign wrap_pulse  = wrap_q;
  assign err         = (state_q == ST_ERROR);
  assign state       = state_q;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Bench for ripple_count_monitor: directed scenarios plus random stimulus,
// checked every cycle against a behavioural model of the monitor.
module tb_ripple_count_monitor;

  localparam int MAXV = 15;
  localparam int MODV = 16;

  logic       Clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr_err = 1'b0;
  logic [3:0] cnt_in = '0;
  logic [3:0] duty = '0;
  logic [3:0] match = '0;

  logic       pwm, match_pulse, wrap_pulse, err;
  logic [7:0] wrap_count;
  logic [1:0] state;

  logic       pwm_s, mp_s, wp_s, err_s, pwm_m, mp_m, wp_m, err_m;
  logic [1:0] wc_s, wc_m, st_s, st_m;

  always #5 Clk = ~Clk;

  ripple_count_monitor #(.CNT_W(4), .WRAP_W(8), .SAT(1'b1)) dut (
    .Clk(Clk), .rst(rst), .en(en), .clr_err(clr_err), .cnt_in(cnt_in),
    .duty(duty), .match(match), .pwm(pwm), .match_pulse(match_pulse),
    .wrap_pulse(wrap_pulse), .wrap_count(wrap_count), .err(err), .state(state)
  );

  ripple_count_monitor #(.CNT_W(4), .WRAP_W(2), .SAT(1'b1)) dut_s (
    .Clk(Clk), .rst(rst), .en(en), .clr_err(clr_err), .cnt_in(cnt_in),
    .duty(duty), .match(match), .pwm(pwm_s), .match_pulse(mp_s),
    .wrap_pulse(wp_s), .wrap_count(wc_s), .err(err_s), .state(st_s)
  );

  ripple_count_monitor #(.CNT_W(4), .WRAP_W(2), .SAT(1'b0)) dut_m (
    .Clk(Clk), .rst(rst), .en(en), .clr_err(clr_err), .cnt_in(cnt_in),
    .duty(duty), .match(match), .pwm(pwm_m), .match_pulse(mp_m),
    .wrap_pulse(wp_m), .wrap_count(wc_m), .err(err_m), .state(st_m)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  int n_pwm = 0, n_match = 0, n_wrap = 0;
  int cur = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wc_model(input int raw, input int w, input bit sat);
    int lim;
    lim = (1 << w) - 1;
    if (sat) return (raw > lim) ? lim : raw;
    return raw % (1 << w);
  endfunction

  // Behavioural model: m_prev/m_cur are the last two sampled counts,
  // m_raw is the unbounded number of wraps since RUN was entered.
  int m_cur = 0, m_prev = 0, m_st = 0, m_duty = 0, m_raw = 0;
  bit e_pwm = 1'b0, e_match = 1'b0, e_wrap = 1'b0;

  always @(posedge Clk) begin : ref_model
    int  nst, nduty, nraw, dlt;
    bit  legal, wrp, arr, wp;
    if (rst) begin
      m_cur <= 0; m_prev <= 0; m_st <= 0; m_duty <= 0; m_raw <= 0;
      e_pwm <= 1'b0; e_match <= 1'b0; e_wrap <= 1'b0;
    end else begin
      nst = m_st; nduty = m_duty; nraw = m_raw; wp = 1'b0;
      dlt   = (m_cur - m_prev + MODV) % MODV;
      legal = (dlt <= 1);
      wrp   = (m_prev == MAXV) && (m_cur == 0);
      arr   = (m_cur != m_prev) && (m_cur == int'(match));
      case (m_st)
        0: if (en) nst = 1;
        1: begin
          if (!en) nst = 0;
          else if (wrp) begin nst = 2; nduty = int'(duty); nraw = 0; end
        end
        2: begin
          if (!legal) nst = 3;
          else if (!en) nst = 0;
          else if (wrp) begin wp = 1'b1; nraw = m_raw + 1; nduty = int'(duty); end
        end
        default: if (clr_err) nst = 0;
      endcase
      e_pwm   <= (nst == 2) && (m_cur < nduty);
      e_match <= (nst == 2) && arr;
      e_wrap  <= wp;
      m_st    <= nst;
      m_duty  <= nduty;
      m_raw   <= nraw;
      m_prev  <= m_cur;
      m_cur   <= int'(cnt_in);
    end
  end

  always @(negedge Clk) begin
    if (chk_on) begin
      check("state", state, m_st);
      check("err", err, (m_st == 3));
      check("pwm", pwm, e_pwm);
      check("match_pulse", match_pulse, e_match);
      check("wrap_pulse", wrap_pulse, e_wrap);
      check("wrap_count", wrap_count, wc_model(m_raw, 8, 1'b1));
      check("wc_sat2", wc_s, wc_model(m_raw, 2, 1'b1));
      check("wc_mod2", wc_m, wc_model(m_raw, 2, 1'b0));
      check("state_s", st_s, m_st);
      check("state_m", st_m, m_st);
      if (pwm) n_pwm <= n_pwm + 1;
      if (match_pulse) n_match <= n_match + 1;
      if (wrap_pulse) n_wrap <= n_wrap + 1;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step_next();
    cur = (cur + 1) % MODV;
    cnt_in = 4'(cur);
    tick();
  endtask

  task automatic step_to(input int t);
    while (cur != t) step_next();
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    chk_on = 1'b1;
    check("rst_state", state, 0);
    check("rst_wrap_count", wrap_count, 0);
    check("rst_pwm", pwm, 0);
    rst = 1'b0;

    // 1: arm and ramp three periods -> RUN, one counted wrap
    en = 1'b1;
    cur = 0; cnt_in = 4'd0; tick();
    repeat (47) step_next();
    tick(); tick();
    check("t1_state", state, 2);
    check("t1_wrap_count", wrap_count, 1);
    check("t1_wrap_pulses", n_wrap, 1);

    // 2: duty 5 -> 5 of 16 cycles high; duty change waits for the wrap
    duty = 4'd5;
    repeat (32) step_next();
    n_pwm = 0;
    repeat (16) step_next();
    check("t2_pwm_high_cycles", n_pwm, 5);
    step_to(6);
    duty = 4'd12;
    step_to(8); step_next();
    check("t2_pwm_old_duty", pwm, 0);
    step_to(15); step_to(8); step_next();
    check("t2_pwm_new_duty", pwm, 1);

    // 3: illegal jump 3->7, then clear back through IDLE to ARMED
    step_to(3);
    cur = 7; cnt_in = 4'd7; tick(); tick();
    check("t3_state", state, 3);
    check("t3_err", err, 1);
    check("t3_pwm", pwm, 0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("t3_clr_state", state, 0);
    tick();
    check("t3_rearm_state", state, 1);

    // 4: match on 9 with the count stalled at 9 for four cycles
    match = 4'd9;
    step_to(15); step_to(2);
    n_match = 0;
    step_to(9);
    repeat (3) tick();
    step_to(12); tick(); tick();
    check("t4_match_pulses", n_match, 1);

    // 5: re-enter RUN, then five wraps
    en = 1'b0; tick(); tick();
    en = 1'b1; tick();
    check("t5_armed", state, 1);
    step_to(15); step_next();
    repeat (80) step_next();
    tick(); tick();
    check("t5_wc_w8", wrap_count, 5);
    check("t5_wc_sat2", wc_s, 3);
    check("t5_wc_mod2", wc_m, 1);

    // 6a: illegal step decided in the same cycle as en=0
    step_to(4);
    cur = 8; cnt_in = 4'd8; tick();
    en = 1'b0; tick();
    check("t6_err_beats_en", state, 3);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    en = 1'b1; tick();

    // 6b: reset while running
    step_to(15); step_next();
    step_to(15); step_to(3);
    rst = 1'b1; tick();
    check("t6_rst_state", state, 0);
    check("t6_rst_wrap_count", wrap_count, 0);
    check("t6_rst_pwm", pwm, 0);
    check("t6_rst_err", err, 0);
    rst = 1'b0;
    cur = 0; cnt_in = 4'd0; tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 85) cur = (cur + 1) % MODV;
      else if (r >= 95) cur = $urandom_range(0, MAXV);
      cnt_in  = 4'(cur);
      en      = ($urandom_range(0, 99) < 97);
      clr_err = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 39) == 0) duty = 4'($urandom_range(0, MAXV));
      if ($urandom_range(0, 59) == 0) match = 4'($urandom_range(0, MAXV));
      rst = ($urandom_range(0, 499) == 0);
      if (rst) cur = 0;
      tick();
    end
    rst = 1'b0; clr_err = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
